// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the set-associative cache and its PLRU tree.
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EVICT,
      FETCH,
      WT_WRITE,
      FL_SCAN,
      FL_WRITE,
      FL_DONE
   } state_t;

   function automatic int byte_width(input int word_size);
      return $clog2(word_size);
   endfunction

   function automatic int offset_width(input int block_size);
      return $clog2(block_size);
   endfunction

   function automatic int index_width(input int number_of_sets);
      return $clog2(number_of_sets);
   endfunction

   function automatic int tag_width(input int address_bits, input int number_of_sets,
                                    input int block_size, input int word_size);
      return address_bits - index_width(number_of_sets) - offset_width(block_size)
             - byte_width(word_size);
   endfunction

   // Heap-ordered tree: node i has children 2i+1 and 2i+2, leaves are the ways left to right.
   function automatic int plru_left(input int node);
      return 2 * node + 1;
   endfunction

   function automatic int plru_right(input int node);
      return 2 * node + 2;
   endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU: picks the victim way from the node bits and computes the bits after an access.
module plru_tree
   import cache_pkg::*;
#(
   parameter int associativity = 8
) (
   input  logic [associativity-2:0]         lru_bits,
   input  logic [$clog2(associativity)-1:0] access_way,
   output logic [$clog2(associativity)-1:0] victim_way,
   output logic [associativity-2:0]         next_lru_bits
);

   localparam int way_w = $clog2(associativity);
   localparam int nodes = 2 * associativity - 1;

   logic [nodes-1:0] victim_path;
   logic [nodes-1:0] access_path;

   // A node bit of 0 sends the victim search left; an access points every path bit away from itself.
   always_comb begin
      victim_path    = '0;
      victim_path[0] = 1'b1;
      for (int i = 0; i < associativity - 1; i++) begin
         victim_path[plru_left(i)]  = victim_path[i] & ~lru_bits[i];
         victim_path[plru_right(i)] = victim_path[i] &  lru_bits[i];
      end

      access_path = '0;
      for (int w = 0; w < associativity; w++)
         access_path[associativity - 1 + w] = (access_way == way_w'(w));
      for (int i = associativity - 2; i >= 0; i--)
         access_path[i] = access_path[plru_left(i)] | access_path[plru_right(i)];

      victim_way = '0;
      for (int w = 0; w < associativity; w++)
         if (victim_path[associativity - 1 + w]) victim_way = way_w'(w);

      next_lru_bits = lru_bits;
      for (int i = 0; i < associativity - 1; i++)
         if (access_path[i]) next_lru_bits[i] = access_path[plru_left(i)];
   end

endmodule

// File: rtl/set_assoc_cache_wb.sv
// N-way set-associative L1 cache, write-back or write-through, with PLRU replacement and flush.
// Optional hit/miss/evict counters are built when CACHE_STATS_EN is defined.
//
// state    | meaning
// IDLE     | serve hits, launch miss handling or a flush
// EVICT    | writing the dirty victim block back to memory
// FETCH    | reading the missed block from memory
// WT_WRITE | write-through of the line just written
// FL_SCAN  | flush: inspect one line per cycle
// FL_WRITE | flush: writing one dirty line back
// FL_DONE  | flush complete, flush_done high
module set_assoc_cache_wb
   import cache_pkg::*;
#(
   parameter int associativity  = 8,
   parameter int number_of_sets = 64,
   parameter int block_size     = 8,
   parameter int word_size      = 8,
   parameter int address_bits   = 64,
   parameter bit write_through  = 1'b0
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [address_bits-1:0]               p_addr,
   input  logic                                  p_read_en,
   input  logic                                  p_write_en,
   input  logic [word_size*8-1:0]                p_write_data,
   input  logic [word_size-1:0]                  p_byte_en,
   output logic [word_size*8-1:0]                p_read_data,
   output logic                                  stall,
   input  logic                                  flush_req,
   output logic                                  flush_done,
   output logic [address_bits-1:0]               m_addr,
   output logic [block_size*word_size*8-1:0]     m_write_data,
   input  logic [block_size*word_size*8-1:0]     m_read_data,
   output logic                                  m_read_en,
   output logic                                  m_write_en,
   input  logic                                  m_stall
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]                           hit_count,
   output logic [31:0]                           miss_count,
   output logic [31:0]                           evict_count
`endif
);

   localparam int byte_w    = byte_width(word_size);
   localparam int off_w     = offset_width(block_size);
   localparam int idx_w     = index_width(number_of_sets);
   localparam int way_w     = $clog2(associativity);
   localparam int tag_w     = tag_width(address_bits, number_of_sets, block_size, word_size);
   localparam int word_bits = word_size * 8;
   localparam int line_bits = block_size * word_bits;
   localparam int lines     = number_of_sets * associativity;
   localparam int line_w    = idx_w + way_w;

   state_t                    state;
   logic [line_bits-1:0]      data_mem [lines];
   logic [tag_w-1:0]          tag_mem  [lines];
   logic [lines-1:0]          valid;
   logic [lines-1:0]          dirty;
   logic [associativity-2:0]  lru_mem  [number_of_sets];
   logic [way_w-1:0]          miss_way;
   logic [line_w-1:0]         scan_line;

   logic [tag_w-1:0]          p_tag;
   logic [idx_w-1:0]          p_idx;
   logic [off_w-1:0]          p_off;
   logic [address_bits-1:0]   p_line_addr;
   logic                      req;
   logic                      unused_byte_bits;

   logic                      hit_any;
   logic [way_w-1:0]          hit_way;
   logic                      inv_found;
   logic [way_w-1:0]          inv_way;
   logic [way_w-1:0]          plru_victim;
   logic [way_w-1:0]          victim;
   logic [way_w-1:0]          lru_access_way;
   logic [associativity-2:0]  next_lru;
   logic [line_w-1:0]         hit_slot;
   logic [line_w-1:0]         victim_slot;
   logic [line_w-1:0]         miss_slot;
   logic [off_w+$clog2(word_bits)-1:0] bit_base;
   logic [line_bits-1:0]      hit_line;
   logic [word_bits-1:0]      hit_word;
   logic [word_bits-1:0]      merged_word;
   logic [line_bits-1:0]      merged_line;
   logic                      victim_dirty;
   logic                      scan_last;

   assign p_tag            = p_addr[address_bits-1 -: tag_w];
   assign p_idx            = p_addr[byte_w+off_w +: idx_w];
   assign p_off            = p_addr[byte_w +: off_w];
   assign p_line_addr      = {p_tag, p_idx, {(off_w+byte_w){1'b0}}};
   assign unused_byte_bits = ^p_addr[byte_w-1:0];
   assign req              = p_read_en | p_write_en;

   // Descending walk so the lowest-numbered invalid way is the one left in inv_way.
   always_comb begin
      hit_any   = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = associativity - 1; w >= 0; w--) begin
         if (valid[{p_idx, way_w'(w)}] && (tag_mem[{p_idx, way_w'(w)}] == p_tag)) begin
            hit_any = 1'b1;
            hit_way = way_w'(w);
         end
         if (!valid[{p_idx, way_w'(w)}]) begin
            inv_found = 1'b1;
            inv_way   = way_w'(w);
         end
      end
   end

   assign lru_access_way = (state == FETCH) ? miss_way : hit_way;

   plru_tree #(.associativity(associativity)) u_plru (
      .lru_bits      (lru_mem[p_idx]),
      .access_way    (lru_access_way),
      .victim_way    (plru_victim),
      .next_lru_bits (next_lru)
   );

   assign victim       = inv_found ? inv_way : plru_victim;
   assign hit_slot     = {p_idx, hit_way};
   assign victim_slot  = {p_idx, victim};
   assign miss_slot    = {p_idx, miss_way};
   assign victim_dirty = !write_through && valid[victim_slot] && dirty[victim_slot];
   assign scan_last    = &scan_line;

   assign bit_base = {p_off, {$clog2(word_bits){1'b0}}};
   assign hit_line = data_mem[hit_slot];
   assign hit_word = hit_line[bit_base +: word_bits];

   always_comb begin
      for (int b = 0; b < word_size; b++)
         merged_word[b*8 +: 8] = p_byte_en[b] ? p_write_data[b*8 +: 8] : hit_word[b*8 +: 8];
      merged_line                       = hit_line;
      merged_line[bit_base +: word_bits] = merged_word;
   end

   assign p_read_data = hit_word;
   assign stall = (state != IDLE) | (req & ~hit_any) | ((state == IDLE) & flush_req & ~req);

   // Line storage carries no reset; valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (state == IDLE && p_write_en && hit_any)
         data_mem[hit_slot] <= merged_line;
      if (state == FETCH && !m_stall) begin
         data_mem[miss_slot] <= m_read_data;
         tag_mem[miss_slot]  <= p_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         valid        <= '0;
         dirty        <= '0;
         for (int s = 0; s < number_of_sets; s++) lru_mem[s] <= '0;
         miss_way     <= '0;
         scan_line    <= '0;
         m_addr       <= '0;
         m_write_data <= '0;
         m_read_en    <= 1'b0;
         m_write_en   <= 1'b0;
         flush_done   <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  if (hit_any) begin
                     lru_mem[p_idx] <= next_lru;
                     if (p_write_en) begin
                        if (write_through) begin
                           m_addr       <= p_line_addr;
                           m_write_data <= merged_line;
                           m_write_en   <= 1'b1;
                           state        <= WT_WRITE;
                        end else begin
                           dirty[hit_slot] <= 1'b1;
                        end
                     end
                  end else begin
                     miss_way <= victim;
                     if (victim_dirty) begin
                        m_addr       <= {tag_mem[victim_slot], p_idx, {(off_w+byte_w){1'b0}}};
                        m_write_data <= data_mem[victim_slot];
                        m_write_en   <= 1'b1;
                        state        <= EVICT;
                     end else begin
                        m_addr    <= p_line_addr;
                        m_read_en <= 1'b1;
                        state     <= FETCH;
                     end
                  end
               end else if (flush_req) begin
                  scan_line <= '0;
                  state     <= FL_SCAN;
               end
            end
            EVICT: begin
               if (!m_stall) begin
                  m_write_en <= 1'b0;
                  m_read_en  <= 1'b1;
                  m_addr     <= p_line_addr;
                  state      <= FETCH;
               end
            end
            FETCH: begin
               if (!m_stall) begin
                  m_read_en        <= 1'b0;
                  valid[miss_slot] <= 1'b1;
                  dirty[miss_slot] <= 1'b0;
                  lru_mem[p_idx]   <= next_lru;
                  state            <= IDLE;
               end
            end
            WT_WRITE: begin
               if (!m_stall) begin
                  m_write_en <= 1'b0;
                  state      <= IDLE;
               end
            end
            FL_SCAN: begin
               if (valid[scan_line] && dirty[scan_line]) begin
                  m_addr       <= {tag_mem[scan_line], scan_line[line_w-1 -: idx_w],
                                   {(off_w+byte_w){1'b0}}};
                  m_write_data <= data_mem[scan_line];
                  m_write_en   <= 1'b1;
                  state        <= FL_WRITE;
               end else if (scan_last) begin
                  flush_done <= 1'b1;
                  state      <= FL_DONE;
               end else begin
                  scan_line <= scan_line + 1'b1;
               end
            end
            FL_WRITE: begin
               if (!m_stall) begin
                  m_write_en       <= 1'b0;
                  dirty[scan_line] <= 1'b0;
                  if (scan_last) begin
                     flush_done <= 1'b1;
                     state      <= FL_DONE;
                  end else begin
                     scan_line <= scan_line + 1'b1;
                     state     <= FL_SCAN;
                  end
               end
            end
            FL_DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   // A missed request hits once after its fill; miss_pending keeps that hit out of hit_count.
   logic miss_pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count    <= '0;
         miss_count   <= '0;
         evict_count  <= '0;
         miss_pending <= 1'b0;
      end else if (state == IDLE && req) begin
         if (hit_any) begin
            if (miss_pending)              miss_pending <= 1'b0;
            else if (hit_count != '1)      hit_count    <= hit_count + 32'd1;
         end else begin
            miss_pending <= 1'b1;
            if (miss_count != '1)          miss_count   <= miss_count + 32'd1;
            if (victim_dirty && evict_count != '1) evict_count <= evict_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_set_assoc_cache_wb.sv
// Directed bench for set_assoc_cache_wb: a write-back instance and a write-through instance.
module tb_set_assoc_cache_wb;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic [63:0]  p_addr, p_write_data, p_read_data;
   logic         p_read_en, p_write_en, stall, flush_req, flush_done;
   logic [7:0]   p_byte_en;
   logic [63:0]  m_addr;
   logic [511:0] m_write_data, m_read_data;
   logic         m_read_en, m_write_en, m_stall;

   logic [63:0]  wt_p_addr, wt_p_write_data, wt_p_read_data;
   logic         wt_p_read_en, wt_p_write_en, wt_stall, wt_flush_req, wt_flush_done;
   logic [7:0]   wt_p_byte_en;
   logic [63:0]  wt_m_addr;
   logic [511:0] wt_m_write_data, wt_m_read_data;
   logic         wt_m_read_en, wt_m_write_en, wt_m_stall;

`ifdef CACHE_STATS_EN
   logic [31:0] hit_count, miss_count, evict_count;
   logic [31:0] wt_hit_count, wt_miss_count, wt_evict_count;
`endif

   set_assoc_cache_wb #(.write_through(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .p_addr(p_addr), .p_read_en(p_read_en),
      .p_write_en(p_write_en), .p_write_data(p_write_data), .p_byte_en(p_byte_en),
      .p_read_data(p_read_data), .stall(stall), .flush_req(flush_req),
      .flush_done(flush_done), .m_addr(m_addr), .m_write_data(m_write_data),
      .m_read_data(m_read_data), .m_read_en(m_read_en), .m_write_en(m_write_en),
      .m_stall(m_stall)
`ifdef CACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count), .evict_count(evict_count)
`endif
   );

   set_assoc_cache_wb #(.write_through(1'b1)) dut_wt (
      .clk(clk), .rst_n(rst_n), .p_addr(wt_p_addr), .p_read_en(wt_p_read_en),
      .p_write_en(wt_p_write_en), .p_write_data(wt_p_write_data), .p_byte_en(wt_p_byte_en),
      .p_read_data(wt_p_read_data), .stall(wt_stall), .flush_req(wt_flush_req),
      .flush_done(wt_flush_done), .m_addr(wt_m_addr), .m_write_data(wt_m_write_data),
      .m_read_data(wt_m_read_data), .m_read_en(wt_m_read_en), .m_write_en(wt_m_write_en),
      .m_stall(wt_m_stall)
`ifdef CACHE_STATS_EN
      , .hit_count(wt_hit_count), .miss_count(wt_miss_count), .evict_count(wt_evict_count)
`endif
   );

   // Memory content: word w of the block at address a is {a[31:0], w}.
   function automatic logic [511:0] blk(input logic [63:0] a);
      logic [511:0] b;
      for (int w = 0; w < 8; w++) b[64*w +: 64] = {a[31:0], 32'(w)};
      return b;
   endfunction

   always_comb m_read_data    = blk(m_addr);
   always_comb wt_m_read_data = blk(wt_m_addr);

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   logic [63:0]  wr_addr_q[$];
   logic [511:0] wr_data_q[$];
   logic [64:0]  ev_q[$];
   int           rd_count = 0;
   int           fd_count = 0;
   int           wt_wr_count = 0;

   always @(posedge clk) begin
      if (rst_n) begin
         if (m_write_en && !m_stall) begin
            wr_addr_q.push_back(m_addr);
            wr_data_q.push_back(m_write_data);
            ev_q.push_back({1'b1, m_addr});
         end
         if (m_read_en && !m_stall) begin
            ev_q.push_back({1'b0, m_addr});
            rd_count++;
         end
         if (flush_done) fd_count++;
         if (wt_m_write_en && !wt_m_stall) wt_wr_count++;
      end
   end

   task automatic cpu_access(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                             input logic [7:0] be, output logic [63:0] rd, output int cyc);
      p_addr = addr; p_write_data = wd; p_byte_en = be;
      p_read_en = ~wr; p_write_en = wr;
      cyc = 0;
      @(negedge clk);
      while (stall && cyc < 100) begin @(negedge clk); cyc++; end
      if (cyc >= 100) check_val("access_timeout", stall, 1'b0);
      rd = p_read_data;
      @(posedge clk); #1;
      p_read_en = 1'b0; p_write_en = 1'b0;
   endtask

   task automatic wt_access(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                            input logic [7:0] be, output logic [63:0] rd, output int cyc);
      wt_p_addr = addr; wt_p_write_data = wd; wt_p_byte_en = be;
      wt_p_read_en = ~wr; wt_p_write_en = wr;
      cyc = 0;
      @(negedge clk);
      while (wt_stall && cyc < 100) begin @(negedge clk); cyc++; end
      if (cyc >= 100) check_val("wt_access_timeout", wt_stall, 1'b0);
      rd = wt_p_read_data;
      @(posedge clk); #1;
      wt_p_read_en = 1'b0; wt_p_write_en = 1'b0;
   endtask

   task automatic run_flush(output int writes, output int pulses);
      int n0, f0, cyc;
      n0 = wr_addr_q.size();
      f0 = fd_count;
      flush_req = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!flush_done && cyc < 3000) begin @(negedge clk); cyc++; end
      check_val("flush_done_seen", flush_done, 1'b1);
      flush_req = 1'b0;
      repeat (4) @(negedge clk);
      writes = wr_addr_q.size() - n0;
      pulses = fd_count - f0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [63:0]  rd;
      logic [511:0] exp_blk;
      logic [511:0] got_blk;
      int           cyc, n_ev, n_wr, writes, pulses;

      rst_n = 1'b0;
      p_addr = '0; p_read_en = 0; p_write_en = 0; p_write_data = '0; p_byte_en = '0;
      flush_req = 0; m_stall = 0;
      wt_p_addr = '0; wt_p_read_en = 0; wt_p_write_en = 0; wt_p_write_data = '0;
      wt_p_byte_en = '0; wt_flush_req = 0; wt_m_stall = 0;
      #12;
      check_val("rst_m_read_en", m_read_en, 1'b0);
      check_val("rst_m_write_en", m_write_en, 1'b0);
      check_val("rst_m_addr", m_addr, 64'h0);
      check_val("rst_m_write_data", m_write_data, 512'h0);
      check_val("rst_flush_done", flush_done, 1'b0);
      check_val("rst_stall", stall, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Cold read: miss, fetch issued one cycle later, hit on the cycle after the fill.
      p_addr = 64'h1000; p_read_en = 1'b1;
      @(negedge clk);
      check_val("t1_stall_on_miss", stall, 1'b1);
      check_val("t1_no_read_cycle0", m_read_en, 1'b0);
      @(negedge clk);
      check_val("t1_read_en_cycle1", m_read_en, 1'b1);
      check_val("t1_read_addr", m_addr, 64'h1000);
      @(negedge clk);
      check_val("t1_stall_after_fill", stall, 1'b0);
      check_val("t1_read_word", p_read_data, 64'h0000_1000_0000_0000);
      @(posedge clk); #1; p_read_en = 1'b0;
      check_val("t1_read_count", rd_count, 1);
      cpu_access(1'b0, 64'h1008, '0, '0, rd, cyc);
      check_val("t1_hit_cycles", cyc, 0);
      check_val("t1_hit_word1", rd, 64'h0000_1000_0000_0001);

      // Byte-masked write hit: low four bytes only, no memory traffic.
      n_ev = ev_q.size();
      cpu_access(1'b1, 64'h1008, 64'hAABB_CCDD_EEFF_1122, 8'h0F, rd, cyc);
      check_val("t2_write_hit_cycles", cyc, 0);
      cpu_access(1'b0, 64'h1008, '0, '0, rd, cyc);
      check_val("t2_merged_word", rd, 64'h0000_1000_EEFF_1122);
      cpu_access(1'b0, 64'h1000, '0, '0, rd, cyc);
      check_val("t2_neighbour_word", rd, 64'h0000_1000_0000_0000);
      check_val("t2_no_mem_traffic", ev_q.size(), n_ev);

      // Fill set 0 with tags 2..8, then tag 9 evicts the dirty line in way 0 first.
      for (int t = 2; t <= 8; t++) begin
         cpu_access(1'b0, 64'(t) << 12, '0, '0, rd, cyc);
         check_val("t3_fill_word", rd, {32'(t) << 12, 32'h0});
      end
      n_ev = ev_q.size();
      cpu_access(1'b0, 64'h9000, '0, '0, rd, cyc);
      check_val("t3_new_line_word", rd, 64'h0000_9000_0000_0000);
      check_val("t3_event_count", ev_q.size(), n_ev + 2);
      if (ev_q.size() >= n_ev + 2) begin
         check_val("t3_evict_first", ev_q[n_ev], {1'b1, 64'h1000});
         check_val("t3_fetch_second", ev_q[n_ev + 1], {1'b0, 64'h9000});
         exp_blk = blk(64'h1000);
         exp_blk[127:64] = 64'h0000_1000_EEFF_1122;
         got_blk = wr_data_q[wr_data_q.size() - 1];
         check_val("t3_evict_data", got_blk, exp_blk);
      end

      // Write-through hit: completes at once, then memory write holds stall while m_stall is high.
      wt_access(1'b0, 64'h1000, '0, '0, rd, cyc);
      check_val("t4_fill_cycles", cyc, 2);
      check_val("t4_fill_word", rd, 64'h0000_1000_0000_0000);
      wt_m_stall = 1'b1;
      wt_access(1'b1, 64'h1000, 64'hAABB_CCDD_EEFF_1122, 8'hF0, rd, cyc);
      check_val("t4_write_cycles", cyc, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("t4_stall_held", wt_stall, 1'b1);
         check_val("t4_write_en_held", wt_m_write_en, 1'b1);
      end
      exp_blk = blk(64'h1000);
      exp_blk[63:0] = 64'hAABB_CCDD_0000_0000;
      check_val("t4_wt_addr", wt_m_addr, 64'h1000);
      check_val("t4_wt_data", wt_m_write_data, exp_blk);
      wt_m_stall = 1'b0;
      @(negedge clk);
      check_val("t4_write_en_dropped", wt_m_write_en, 1'b0);
      check_val("t4_stall_released", wt_stall, 1'b0);
      check_val("t4_write_count", wt_wr_count, 1);
      @(posedge clk); #1;
      wt_access(1'b0, 64'h1000, '0, '0, rd, cyc);
      check_val("t4_readback", rd, 64'hAABB_CCDD_0000_0000);

      // Three dirty lines, then flush writes exactly those in scan order.
      cpu_access(1'b1, 64'h2000, 64'h1111_1111_1111_1111, 8'hFF, rd, cyc);
      cpu_access(1'b1, 64'h3010, 64'h7700_0000_0000_0000, 8'h80, rd, cyc);
      cpu_access(1'b1, 64'h1040, 64'h0000_0000_0000_0055, 8'h01, rd, cyc);
      check_val("t5_alloc_write_cycles", cyc, 2);
      n_wr = wr_addr_q.size();
      run_flush(writes, pulses);
      check_val("t5_flush_writes", writes, 3);
      check_val("t5_flush_pulses", pulses, 1);
      if (wr_addr_q.size() >= n_wr + 3) begin
         check_val("t5_flush_addr0", wr_addr_q[n_wr], 64'h2000);
         check_val("t5_flush_addr1", wr_addr_q[n_wr + 1], 64'h3000);
         check_val("t5_flush_addr2", wr_addr_q[n_wr + 2], 64'h1040);
         got_blk = wr_data_q[n_wr];
         check_val("t5_flush_data0", got_blk[63:0], 64'h1111_1111_1111_1111);
      end
      run_flush(writes, pulses);
      check_val("t5_reflush_writes", writes, 0);
      check_val("t5_reflush_pulses", pulses, 1);
      cpu_access(1'b0, 64'h2000, '0, '0, rd, cyc);
      check_val("t5_hit_2000_cycles", cyc, 0);
      check_val("t5_hit_2000_word", rd, 64'h1111_1111_1111_1111);
      cpu_access(1'b0, 64'h3010, '0, '0, rd, cyc);
      check_val("t5_hit_3010_word", rd, 64'h7700_3000_0000_0002);
      cpu_access(1'b0, 64'h1040, '0, '0, rd, cyc);
      check_val("t5_hit_1040_cycles", cyc, 0);
      check_val("t5_hit_1040_word", rd, 64'h0000_1040_0000_0055);

      // Reset in the middle of a stalled fetch drops the enables without a clock edge.
      m_stall = 1'b1;
      p_addr = 64'hA000; p_read_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_val("t6_fetch_pending", m_read_en, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check_val("t6_read_en_reset", m_read_en, 1'b0);
      check_val("t6_write_en_reset", m_write_en, 1'b0);
      check_val("t6_addr_reset", m_addr, 64'h0);
      p_read_en = 1'b0; m_stall = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      cpu_access(1'b0, 64'h2000, '0, '0, rd, cyc);
      check_val("t6_miss_2000_cycles", cyc, 2);
      check_val("t6_miss_2000_word", rd, 64'h0000_2000_0000_0000);
      cpu_access(1'b0, 64'h1040, '0, '0, rd, cyc);
      check_val("t6_miss_1040_cycles", cyc, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
